// File: rtl/buzzer_scheduler.sv
// Round-robin scheduler that shares one tone generator between four note requesters.
// Each accepted note plays for its duration in ms, then a programmable silent gap follows.
module buzzer_scheduler #(
    parameter int unsigned MS_DIV = 50000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  reqValid,
    input  logic [31:0] reqNote,
    input  logic [31:0] reqVelo,
    input  logic [63:0] reqTime,
    output logic [3:0]  reqReady,
    input  logic [7:0]  gapTime,
    input  logic        mute,
    output logic [7:0]  noteOut,
    output logic [7:0]  veloOut,
    output logic        playing,
    output logic [1:0]  grantId,
    output logic        busy,
    output logic [3:0]  done
);

    localparam int unsigned PreW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(MS_DIV - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StGap  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      note_q, note_d;
    logic [7:0]      velo_q, velo_d;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      last_grant_q, last_grant_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic [3:0]      done_q, done_d;
    logic [7:0]      note_out_q, note_out_d;
    logic [7:0]      velo_out_q, velo_out_d;
    logic            playing_q, playing_d;
    logic            busy_q, busy_d;

    logic            win_valid;
    logic [1:0]      win_id;
    logic [1:0]      cand;
    logic            accept;
    logic [7:0]      sel_note;
    logic [7:0]      sel_velo;
    logic [15:0]     sel_time;
    logic            pre_wrap;

    // Search starts just after the last winner, so the last winner is checked last.
    always_comb begin
        win_valid = 1'b0;
        win_id    = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!win_valid && reqValid[cand]) begin
                win_valid = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign accept   = (state_q == StIdle) && win_valid;
    assign reqReady = accept ? (4'b0001 << win_id) : 4'b0000;

    assign sel_note = reqNote[{win_id, 3'b000} +: 8];
    assign sel_velo = reqVelo[{win_id, 3'b000} +: 8];
    assign sel_time = reqTime[{win_id, 4'b0000} +: 16];

    assign pre_wrap = (pre_q == PreMax);

    always_comb begin
        state_d      = state_q;
        note_d       = note_q;
        velo_d       = velo_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        pre_d        = pre_q;
        done_d       = 4'b0000;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    note_d       = sel_note;
                    velo_d       = sel_velo;
                    grant_d      = win_id;
                    last_grant_d = win_id;
                    if (sel_time != 16'd0) begin
                        state_d = StPlay;
                        cnt_d   = sel_time;
                        pre_d   = '0;
                    end else begin
                        // Zero-length note: nothing is played, the owner just sees done.
                        done_d = 4'b0001 << win_id;
                    end
                end
            end

            StPlay: begin
                if (pre_wrap) begin
                    pre_d = '0;
                    if (cnt_q == 16'd1) begin
                        done_d = 4'b0001 << grant_q;
                        if (gapTime != 8'd0) begin
                            state_d = StGap;
                            cnt_d   = {8'd0, gapTime};
                        end else begin
                            state_d = StIdle;
                            cnt_d   = 16'd0;
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end

            StGap: begin
                if (pre_wrap) begin
                    pre_d = '0;
                    if (cnt_q == 16'd1) begin
                        state_d = StIdle;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        playing_d  = (state_d == StPlay);
        busy_d     = (state_d != StIdle);
        note_out_d = (playing_d && !mute) ? note_d : 8'd0;
        velo_out_d = playing_d ? velo_d : 8'd0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            note_q       <= 8'd0;
            velo_q       <= 8'd0;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
            cnt_q        <= 16'd0;
            pre_q        <= '0;
            done_q       <= 4'b0000;
            note_out_q   <= 8'd0;
            velo_out_q   <= 8'd0;
            playing_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            note_q       <= note_d;
            velo_q       <= velo_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            pre_q        <= pre_d;
            done_q       <= done_d;
            note_out_q   <= note_out_d;
            velo_out_q   <= velo_out_d;
            playing_q    <= playing_d;
            busy_q       <= busy_d;
        end
    end

    assign noteOut = note_out_q;
    assign veloOut = velo_out_q;
    assign playing = playing_q;
    assign busy    = busy_q;
    assign grantId = grant_q;
    assign done    = done_q;

endmodule
